// File: rtl/divider.sv
// divider: 32-bit signed restoring divider, one quotient bit per clock.
// Define DIV_REMAINDER_EN to add the signed data_remainder output.

module divider_lt32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        lt,
   output logic [31:0] diff
);

   logic [32:0] wide;

   // Borrow out of a-b is the unsigned less-than; the low bits are the difference
   always_comb begin
      wide = {1'b0, a} - {1'b0, b};
      lt   = wide[32];
      diff = wide[31:0];
   end

endmodule

module divider (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_DIV,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
`ifdef DIV_REMAINDER_EN
   ,
   output logic [31:0] data_remainder
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   // dividend bits shift out the top while quotient bits shift in below
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] prem_q, prem_d;
   logic [31:0] dvs_q, dvs_d;
   logic        qsign_q, qsign_d;
   logic        dz_q, dz_d;
   logic        ov_q, ov_d;
   logic [31:0] res_q, res_d;
   logic        exc_q, exc_d;
   logic        rdy_q, rdy_d;
`ifdef DIV_REMAINDER_EN
   logic        rsign_q, rsign_d;
   logic [31:0] rout_q, rout_d;
`endif

   logic [31:0] prem_sh;
   logic        prem_lt;
   logic [31:0] prem_sub;
   logic [31:0] a_abs;
   logic [31:0] b_abs;

   divider_lt32 u_lt (
      .a    (prem_sh),
      .b    (dvs_q),
      .lt   (prem_lt),
      .diff (prem_sub)
   );

   // Operand magnitudes and the next partial remainder candidate
   always_comb begin
      prem_sh = {prem_q[30:0], dvd_q[31]};
      a_abs   = data_operandA[31] ? (32'd0 - data_operandA)
                                  : data_operandA;
      b_abs   = data_operandB[31] ? (32'd0 - data_operandB)
                                  : data_operandB;
   end

   // Next-state, datapath step and output formatting
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      prem_d  = prem_q;
      dvs_d   = dvs_q;
      qsign_d = qsign_q;
      dz_d    = dz_q;
      ov_d    = ov_q;
      res_d   = res_q;
      exc_d   = exc_q;
      rdy_d   = 1'b0;
`ifdef DIV_REMAINDER_EN
      rsign_d = rsign_q;
      rout_d  = rout_q;
`endif

      unique case (state_q)
         IDLE: begin
            state_d = IDLE;
         end
         BUSY: begin
            if (prem_lt) begin
               prem_d = prem_sh;
               dvd_d  = {dvd_q[30:0], 1'b0};
            end else begin
               prem_d = prem_sub;
               dvd_d  = {dvd_q[30:0], 1'b1};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = DONE;
            end
         end
         DONE: begin
            rdy_d   = 1'b1;
            state_d = IDLE;
            if (dz_q) begin
               res_d = 32'd0;
               exc_d = 1'b1;
            end else if (ov_q) begin
               res_d = 32'h8000_0000;
               exc_d = 1'b1;
            end else begin
               res_d = qsign_q ? (32'd0 - dvd_q) : dvd_q;
               exc_d = 1'b0;
            end
`ifdef DIV_REMAINDER_EN
            if (dz_q || ov_q) begin
               rout_d = 32'd0;
            end else begin
               rout_d = rsign_q ? (32'd0 - prem_q) : prem_q;
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A start strobe in any state (re)loads operands, aborting a busy op
      if (ctrl_DIV) begin
         state_d = BUSY;
         cnt_d   = 6'd0;
         dvd_d   = a_abs;
         prem_d  = 32'd0;
         dvs_d   = b_abs;
         qsign_d = data_operandA[31] ^ data_operandB[31];
         dz_d    = (data_operandB == 32'd0);
         ov_d    = (data_operandA == 32'h8000_0000) &&
                   (data_operandB == 32'hFFFF_FFFF);
`ifdef DIV_REMAINDER_EN
         rsign_d = data_operandA[31];
`endif
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         dvd_q   <= 32'd0;
         prem_q  <= 32'd0;
         dvs_q   <= 32'd0;
         qsign_q <= 1'b0;
         dz_q    <= 1'b0;
         ov_q    <= 1'b0;
         res_q   <= 32'd0;
         exc_q   <= 1'b0;
         rdy_q   <= 1'b0;
`ifdef DIV_REMAINDER_EN
         rsign_q <= 1'b0;
         rout_q  <= 32'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         prem_q  <= prem_d;
         dvs_q   <= dvs_d;
         qsign_q <= qsign_d;
         dz_q    <= dz_d;
         ov_q    <= ov_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
         rdy_q   <= rdy_d;
`ifdef DIV_REMAINDER_EN
         rsign_q <= rsign_d;
         rout_q  <= rout_d;
`endif
      end
   end

   assign data_result    = res_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
`ifdef DIV_REMAINDER_EN
   assign data_remainder = rout_q;
`endif

endmodule

// File: tb/tb_divider.sv
// tb_divider: scoreboard bench for the divider.
// Build with DIV_REMAINDER_EN to also check data_remainder.

module tb_divider;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_operandA = 32'd0;
   logic [31:0] data_operandB = 32'd0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
`ifdef DIV_REMAINDER_EN
   logic [31:0] data_remainder;
`endif

   typedef struct {
      logic [31:0] res;
      logic        exc;
      logic [31:0] rem;
      int          t0;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          rdy_cnt = 0;
   int          pushed = 0;
   logic        rdy_prev = 1'b0;
   logic [31:0] last_res = 32'd0;

   divider dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
`ifdef DIV_REMAINDER_EN
      ,
      .data_remainder (data_remainder)
`endif
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t e;
      e.t0 = 0;
      if (b == 32'd0) begin
         e.res = 32'd0;
         e.exc = 1'b1;
         e.rem = 32'd0;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.res = 32'h8000_0000;
         e.exc = 1'b1;
         e.rem = 32'd0;
      end else begin
         e.res = $signed(a) / $signed(b);
         e.exc = 1'b0;
         e.rem = $signed(a) % $signed(b);
      end
      return e;
   endfunction

   // Returns at the falling edge just after the start edge E0
   task automatic start(input logic [31:0] a,
                        input logic [31:0] b,
                        input bit push);
      exp_t e;
      @(negedge clock);
      ctrl_DIV = 1'b1;
      data_operandA = a;
      data_operandB = b;
      if (push) begin
         e = model(a, b);
         e.t0 = cyc + 1;
         sb.push_back(e);
         pushed++;
         last_res = e.res;
      end
      @(negedge clock);
      ctrl_DIV = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   task automatic drain;
      for (int i = 0; i < 80 && sb.size() != 0; i++) begin
         @(negedge clock);
      end
      check("drain", sb.size(), 0);
   endtask

   // Completion monitor: pop the oldest expectation on every RDY pulse
   always @(negedge clock) begin
      if (data_resultRDY === 1'b1) begin
         rdy_cnt++;
         check("rdy_twice", {31'd0, rdy_prev}, 0);
         check("rdy_expected", {31'd0, sb.size() != 0}, 1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("res", data_result, mon_e.res);
            check("exc", {31'd0, data_exception}, {31'd0, mon_e.exc});
            check("latency", cyc - mon_e.t0, 33);
`ifdef DIV_REMAINDER_EN
            check("rem", data_remainder, mon_e.rem);
`endif
         end
      end
      rdy_prev = data_resultRDY;
   end

   logic [31:0] ta [12];
   logic [31:0] tb [12];

   initial begin
      ta[0]  = 32'd100;        tb[0]  = 32'd7;
      ta[1]  = 32'hFFFF_FF9C;  tb[1]  = 32'd7;
      ta[2]  = 32'd5;          tb[2]  = 32'd0;
      ta[3]  = 32'h8000_0000;  tb[3]  = 32'hFFFF_FFFF;
      ta[4]  = 32'd100;        tb[4]  = 32'hFFFF_FFF9;
      ta[5]  = 32'hFFFF_FF9C;  tb[5]  = 32'hFFFF_FFF9;
      ta[6]  = 32'd0;          tb[6]  = 32'd5;
      ta[7]  = 32'd7;          tb[7]  = 32'd100;
      ta[8]  = 32'h7FFF_FFFF;  tb[8]  = 32'd1;
      ta[9]  = 32'h8000_0000;  tb[9]  = 32'd1;
      ta[10] = 32'h8000_0000;  tb[10] = 32'd2;
      ta[11] = 32'hFFFF_FFFF;  tb[11] = 32'hFFFF_FFFF;

      repeat (3) @(negedge clock);
      reset = 1'b0;
      check("rst_res", data_result, 0);
      check("rst_exc", {31'd0, data_exception}, 0);
      check("rst_rdy", {31'd0, data_resultRDY}, 0);
`ifdef DIV_REMAINDER_EN
      check("rst_rem", data_remainder, 0);
`endif

      for (int i = 0; i < 12; i++) begin
         start(ta[i], tb[i], 1'b1);
         drain();
      end

      repeat (3) @(negedge clock);
      check("hold", data_result, last_res);
      check("rdy_low", {31'd0, data_resultRDY}, 0);

      for (int i = 0; i < 6; i++) begin
         start($urandom, $urandom_range(1, 5000) ^ {32{i[0]}}, 1'b1);
         drain();
      end

      // Abort: restart sampled at E10 of a running op
      start(32'd50, 32'd5, 1'b0);
      repeat (8) @(negedge clock);
      start(32'd9, 32'd3, 1'b1);
      drain();
      check("abort_res", data_result, 32'd3);

      // Back-to-back: second start sampled at E33 while in DONE
      start(32'd1000, 32'd33, 1'b1);
      repeat (31) @(negedge clock);
      start(32'hFFFF_FC18, 32'd9, 1'b1);
      drain();

      // Reset sampled at E20 drops the op with no RDY
      start(32'd77, 32'd4, 1'b0);
      repeat (19) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("rstb_res", data_result, 0);
      check("rstb_exc", {31'd0, data_exception}, 0);
      check("rstb_rdy", {31'd0, data_resultRDY}, 0);
      reset = 1'b0;
      repeat (40) @(negedge clock);

      start(32'd100, 32'd7, 1'b1);
      drain();
      check("rdy_count", rdy_cnt, pushed);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have one clock, `clock`, and one reset, `reset`. The reset is synchronous and active-high.
REQ-002 Ports, in this order:
- `clock`  input  1  rising-edge clock.
- `reset`  input  1  synchronous active-high reset.
- `ctrl_DIV`  input  1  start strobe; one-cycle pulse.
- `data_operandA`  input  32  dividend; signed two's complement.
- `data_operandB`  input  32  divisor; signed two's complement.
- `data_result`  output  32  quotient; registered.
- `data_exception`  output  1  error flag: divide-by-zero or overflow; registered.
- `data_resultRDY`  output  1  completion pulse; registered.
- `data_remainder`  output  32  remainder; present only with DIV_REMAINDER_EN.

Function
REQ-003 SHALL implement FSM states IDLE, BUSY and DONE.
- IDLE->BUSY: `ctrl_DIV`=1.
- BUSY->DONE: iteration count reaches 32.
- DONE->IDLE: unconditionally after one cycle.
- DONE->BUSY: directly, if `ctrl_DIV`=1 in DONE.
REQ-004 At the edge sampling `ctrl_DIV`=1 (edge E0), the block SHALL latch:
- |A| and |B| as 32-bit unsigned magnitudes;
- quotient sign = A[31]^B[31];
- remainder sign = A[31];
- the zero-divisor flag (B==0);
- the overflow flag (A==32'h80000000 and B==32'hFFFFFFFF).
REQ-005 Edges E1..E32 SHALL each perform one restoring-division step, MSB first:
- shift the partial remainder left, bringing in the next dividend bit;
- compare it with |B| using the team's 32-bit unsigned lessThan comparator;
- if not less-than, subtract |B| and set the quotient bit to 1; otherwise set the quotient bit to 0.
REQ-006 The partial remainder SHALL be 32 bits unsigned. No 33rd bit is needed, since 2R+1 <= 2|B|-1 <= 2^32-1.
REQ-007 At edge E33 the block SHALL register its outputs as follows:
- `data_result` = the quotient, negated if the quotient sign is 1;
- `data_exception` = 0;
- `data_resultRDY` = 1 for exactly one cycle.
REQ-008 Divide-by-zero SHALL keep the same timing as a normal operation, with `data_result`=0 and `data_exception`=1 at E33.
REQ-009 Overflow SHALL keep the same timing as a normal operation, with `data_result`=32'h80000000 and `data_exception`=1 at E33.
REQ-010 Rounding SHALL truncate toward zero. The remainder SHALL take the sign of the dividend.
REQ-011 `data_result` and `data_exception` SHALL hold their values from E33 until the next completion or reset.
REQ-012 `ctrl_DIV`=1 while in BUSY SHALL abort the current operation:
- the new operands are latched at that edge;
- the counter restarts at 0;
- no `data_resultRDY` is issued for the aborted operation.
REQ-013 Operand inputs SHALL be ignored except at the start edge. They MAY change freely during BUSY.
REQ-014 `data_resultRDY` SHALL never be high for two consecutive cycles. The only exception is back-to-back completions, which cannot occur because each operation takes at least 33 cycles.

Reset
REQ-015 `reset`=1 at a rising edge SHALL force the following, with priority over `ctrl_DIV`:
- state = IDLE;
- counter = 0;
- `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0 (and `data_remainder` = 0 when present).
REQ-016 Reset asserted in BUSY SHALL discard the in-flight operation with no RDY pulse. The first `ctrl_DIV` after reset deasserts SHALL start normally.

Configuration
REQ-017 Macro DIV_REMAINDER_EN:
- Defined: `data_remainder` SHALL exist and SHALL be registered at E33 as the signed remainder per REQ-010. It SHALL be 0 on divide-by-zero and on overflow.
- Undefined: the port and the remainder-sign register SHALL be absent. Quotient behaviour and timing SHALL be unchanged.

Verification
REQ-018 A=100, B=7, start -> after 33 cycles, RDY pulses once; result=14, exception=0, remainder=2.
REQ-019 A=-100 (32'hFFFFFF9C), B=7 -> result=-14 (32'hFFFFFFF2), remainder=-2.
REQ-020 A=5, B=0 -> at E33, result=0, exception=1, RDY=1.
REQ-021 A=32'h80000000, B=32'hFFFFFFFF -> result=32'h80000000, exception=1.
REQ-022 Two abort cases:
- Start with A=50, B=5, then restart at E10 with A=9, B=3 -> exactly one RDY, 33 cycles after the restart; result=3.
- Reset at E20 of an operation -> no RDY pulse; all outputs 0 on the next cycle.
